// File: rtl/avaliador_pkg.sv
// Shared types for the guess evaluator: FSM states and the per-guess classification record.
package avaliador_pkg;

  typedef enum logic [2:0] {
    IDLE,
    AGUARDA,
    AVALIA,
    VITORIA,
    DERROTA
  } estado_t;

  typedef struct packed {
    logic igual;
    logic perto;
    logic errada;
    logic maior;
  } classe_t;

endpackage

// File: rtl/classificador_diff.sv
// Combinational classifier: compares a guess against the secret and reports
// equal / near (within TOL) / wrong plus direction.
module classificador_diff
  import avaliador_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int TOL   = 3
) (
  input  logic [WIDTH-1:0] senha,
  input  logic [WIDTH-1:0] tentativa,
  output classe_t          classe
);

  localparam logic [WIDTH:0] TOL_V = (WIDTH+1)'(TOL);

  logic [WIDTH:0] diff;
  logic [WIDTH:0] mag;
  logic           sinal;
  logic           zero;

  // One extra bit keeps the difference exact; the magnitude never wraps.
  always_comb begin
    diff         = {1'b0, tentativa} - {1'b0, senha};
    sinal        = diff[WIDTH];
    mag          = sinal ? -diff : diff;
    zero         = (mag == '0);
    classe.igual  = zero;
    classe.perto  = !zero && (mag <= TOL_V);
    classe.errada = (mag > TOL_V);
    classe.maior  = !sinal && !zero;
  end

endmodule

// File: rtl/avaliador_tentativa.sv
// Sequential guess evaluator: latches a secret, accepts guesses by valid/ready,
// classifies each one and tracks remaining attempts until win or loss.
module avaliador_tentativa
  import avaliador_pkg::*;
#(
  parameter  int WIDTH     = 4,
  parameter  int TOL       = 3,
  parameter  int MAX_TRIES = 7,
  localparam int RW        = $clog2(MAX_TRIES + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] senha,
  input  logic             tentativa_valid,
  input  logic [WIDTH-1:0] tentativa,
  output logic             tentativa_ready,
  output logic             result_valid,
  output logic             igual,
  output logic             perto,
  output logic             errada,
  output logic             maior,
  output logic [RW-1:0]    tentativas_rest,
  output logic             vitoria,
  output logic             derrota
);

  estado_t          estado, estado_n;
  logic [WIDTH-1:0] senha_r, senha_n;
  logic [WIDTH-1:0] tent_r, tent_n;
  classe_t          classe_r, classe_n, classe_w;
  logic [RW-1:0]    rest_r, rest_n;
  logic             vit_r, vit_n;
  logic             der_r, der_n;
  logic             rv_r, rv_n;

  classificador_diff #(
    .WIDTH (WIDTH),
    .TOL   (TOL)
  ) u_class (
    .senha     (senha_r),
    .tentativa (tent_r),
    .classe    (classe_w)
  );

  assign tentativa_ready = (estado == AGUARDA) && !start;

  always_comb begin
    estado_n = estado;
    senha_n  = senha_r;
    tent_n   = tent_r;
    classe_n = classe_r;
    rest_n   = rest_r;
    vit_n    = vit_r;
    der_n    = der_r;
    rv_n     = 1'b0;
    case (estado)
      AVALIA: begin
        classe_n = classe_w;
        rest_n   = rest_r - RW'(1);
        rv_n     = 1'b1;
        if (classe_w.igual) begin
          estado_n = VITORIA;
          vit_n    = 1'b1;
        end else if (rest_n == '0) begin
          estado_n = DERROTA;
          der_n    = 1'b1;
        end else begin
          estado_n = AGUARDA;
        end
      end
      default: begin
        // start outranks a guess presented in the same cycle
        if (start) begin
          estado_n = AGUARDA;
          senha_n  = senha;
          classe_n = '0;
          rest_n   = RW'(MAX_TRIES);
          vit_n    = 1'b0;
          der_n    = 1'b0;
        end else if (estado == AGUARDA && tentativa_valid) begin
          estado_n = AVALIA;
          tent_n   = tentativa;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado   <= IDLE;
      senha_r  <= '0;
      tent_r   <= '0;
      classe_r <= '0;
      rest_r   <= '0;
      vit_r    <= 1'b0;
      der_r    <= 1'b0;
      rv_r     <= 1'b0;
    end else begin
      estado   <= estado_n;
      senha_r  <= senha_n;
      tent_r   <= tent_n;
      classe_r <= classe_n;
      rest_r   <= rest_n;
      vit_r    <= vit_n;
      der_r    <= der_n;
      rv_r     <= rv_n;
    end
  end

  assign result_valid    = rv_r;
  assign igual           = classe_r.igual;
  assign perto           = classe_r.perto;
  assign errada          = classe_r.errada;
  assign maior           = classe_r.maior;
  assign tentativas_rest = rest_r;
  assign vitoria         = vit_r;
  assign derrota         = der_r;

endmodule

// File: tb/tb_avaliador_tentativa.sv
// Scoreboard bench for avaliador_tentativa: directed scenarios plus random
// traffic checked against an arithmetic model of the guessing rules.
module tb_avaliador_tentativa;

  localparam int WIDTH     = 4;
  localparam int TOL       = 3;
  localparam int MAX_TRIES = 3;
  localparam int RW        = $clog2(MAX_TRIES + 1);

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic [WIDTH-1:0] senha = '0;
  logic             tentativa_valid = 1'b0;
  logic [WIDTH-1:0] tentativa = '0;
  logic             tentativa_ready, result_valid;
  logic             igual, perto, errada, maior, vitoria, derrota;
  logic [RW-1:0]    tentativas_rest;

  avaliador_tentativa #(
    .WIDTH     (WIDTH),
    .TOL       (TOL),
    .MAX_TRIES (MAX_TRIES)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .senha           (senha),
    .tentativa_valid (tentativa_valid),
    .tentativa       (tentativa),
    .tentativa_ready (tentativa_ready),
    .result_valid    (result_valid),
    .igual           (igual),
    .perto           (perto),
    .errada          (errada),
    .maior           (maior),
    .tentativas_rest (tentativas_rest),
    .vitoria         (vitoria),
    .derrota         (derrota)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit igual, perto, errada, maior;
    int rest;
    bit vit, der;
  } exp_t;

  exp_t sb[$];
  exp_t m_cur, m_pend;
  int   m_secret = 0;
  int   m_rest = 0;
  int   m_phase = 0;   // 0 idle/over, 1 waiting for guess, 2 evaluating
  bit   m_rv = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic exp_t zero_exp();
    exp_t e;
    e = '{0, 0, 0, 0, 0, 0, 0};
    return e;
  endfunction

  function automatic exp_t judge(int secret, int guess, int rest_after);
    exp_t e;
    int d, a;
    d = guess - secret;
    a = (d < 0) ? -d : d;
    e.igual  = (a == 0);
    e.perto  = (a != 0) && (a <= TOL);
    e.errada = (a > TOL);
    e.maior  = (d > 0);
    e.rest   = rest_after;
    e.vit    = e.igual;
    e.der    = !e.igual && (rest_after == 0);
    return e;
  endfunction

  function automatic bit same(exp_t e);
    return igual == e.igual && perto == e.perto && errada == e.errada &&
           maior == e.maior && int'(tentativas_rest) == e.rest &&
           vitoria == e.vit && derrota == e.der;
  endfunction

  // Reference model: advances on each rising edge from the applied inputs.
  always @(posedge clk) begin
    if (!reset) begin
      m_rv = 1'b0;
      if (m_phase == 2) begin
        m_cur   = m_pend;
        m_rv    = 1'b1;
        m_phase = (m_pend.vit || m_pend.der) ? 0 : 1;
      end else if (start) begin
        m_secret = int'(senha);
        m_rest   = MAX_TRIES;
        m_phase  = 1;
        m_cur    = zero_exp();
        m_cur.rest = MAX_TRIES;
      end else if (m_phase == 1 && tentativa_valid) begin
        m_rest  = m_rest - 1;
        m_pend  = judge(m_secret, int'(tentativa), m_rest);
        sb.push_back(m_pend);
        m_phase = 2;
      end
    end
  end

  // Monitor: samples on the falling edge, away from input changes.
  always @(negedge clk) begin
    if (!reset) begin
      n_cmp++;
      if (tentativa_ready !== (m_phase == 1 && !start)) begin
        n_err++;
        $display("FAIL ready t=%0t: got %b exp %b", $time, tentativa_ready, (m_phase == 1 && !start));
      end
      n_cmp++;
      if (result_valid !== m_rv) begin
        n_err++;
        $display("FAIL result_valid t=%0t: got %b exp %b", $time, result_valid, m_rv);
      end
      n_cmp++;
      if (!same(m_cur)) begin
        n_err++;
        $display("FAIL outputs t=%0t: got ig%b pe%b er%b ma%b rest%0d v%b d%b exp ig%b pe%b er%b ma%b rest%0d v%b d%b",
                 $time, igual, perto, errada, maior, tentativas_rest, vitoria, derrota,
                 m_cur.igual, m_cur.perto, m_cur.errada, m_cur.maior, m_cur.rest, m_cur.vit, m_cur.der);
      end
      if (result_valid) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL scoreboard t=%0t: got result_valid exp no pending guess", $time);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (!same(e)) begin
            n_err++;
            $display("FAIL result t=%0t: got ig%b pe%b er%b ma%b rest%0d v%b d%b exp ig%b pe%b er%b ma%b rest%0d v%b d%b",
                     $time, igual, perto, errada, maior, tentativas_rest, vitoria, derrota,
                     e.igual, e.perto, e.errada, e.maior, e.rest, e.vit, e.der);
          end
        end
      end
    end
  end

  task automatic cyc(input bit st, input int sen, input bit v, input int g);
    @(posedge clk);
    #1;
    start           = st;
    senha           = WIDTH'(sen);
    tentativa_valid = v;
    tentativa       = WIDTH'(g);
  endtask

  task automatic guess(input int g);
    cyc(0, 0, 1, g);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
  endtask

  task automatic check_zero(input string tag);
    n_cmp++;
    if ({tentativa_ready, result_valid, igual, perto, errada, maior,
         tentativas_rest, vitoria, derrota} !== '0) begin
      n_err++;
      $display("FAIL %s: got rdy%b rv%b ig%b pe%b er%b ma%b rest%0d v%b d%b exp all zero",
               tag, tentativa_ready, result_valid, igual, perto, errada, maior,
               tentativas_rest, vitoria, derrota);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    sb.delete();
    m_phase = 0;
    m_rv    = 1'b0;
    m_cur   = zero_exp();
    #1;
    check_zero("reset_outputs");
  endtask

  initial begin
    m_cur = zero_exp();
    #12;
    check_zero("reset_initial");
    reset = 1'b0;

    // immediate win, then guesses ignored
    cyc(1, 9, 0, 0);
    guess(9);
    cyc(0, 0, 1, 3); cyc(0, 0, 1, 9); cyc(0, 0, 0, 0);

    // near above, near below, wrong -> loss
    cyc(1, 9, 0, 0);
    guess(12); guess(6); guess(5);
    cyc(0, 0, 1, 9); cyc(0, 0, 0, 0);

    // width extremes and inclusive tolerance
    cyc(1, 0, 0, 0);
    guess(15);
    cyc(1, 15, 0, 0);
    guess(0); guess(12);

    // start and guess in the same waiting cycle: start wins
    cyc(1, 5, 0, 0);
    cyc(1, 7, 1, 7);
    cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
    guess(7);

    // asynchronous reset while evaluating
    cyc(1, 4, 0, 0);
    cyc(0, 0, 1, 4);
    @(posedge clk);
    #3;
    do_reset();
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 4);
    cyc(0, 0, 0, 0);

    // valid held high: one guess every two cycles
    cyc(1, 2, 0, 0);
    for (int i = 0; i < 8; i++) cyc(0, 0, 1, int'($urandom_range(0, 15)));
    cyc(0, 0, 0, 0);

    // random traffic
    for (int i = 0; i < 400; i++)
      cyc(($urandom_range(0, 9) == 0), int'($urandom_range(0, 15)),
          ($urandom_range(0, 1) == 1), int'($urandom_range(0, 15)));
    cyc(0, 0, 0, 0); cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
    @(negedge clk);

    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending results exp 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
